// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: requester handshake and SPI-master signals around the arbiter
interface spi_arbiter_if #(parameter int DATA_W = 8);
  logic req0, req1;
  logic [DATA_W-1:0] tx0, tx1;
  logic ack0, ack1;
  logic [DATA_W-1:0] rx_data;
  logic err, busy, spi_start;
  logic [DATA_W-1:0] spi_tx;
  logic spi_sel, spi_done;
  logic [DATA_W-1:0] spi_rx;
  modport slave (
    input  req0, req1, tx0, tx1, spi_done, spi_rx,
    output ack0, ack1, rx_data, err, busy, spi_start, spi_tx, spi_sel
  );
  modport master (
    output req0, req1, tx0, tx1, spi_done, spi_rx,
    input  ack0, ack1, rx_data, err, busy, spi_start, spi_tx, spi_sel
  );
endinterface

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter sharing one SPI master between two requesters, with WAIT timeout
module spi_arbiter #(
  parameter int DATA_W = 8,
  parameter int TIMEOUT = 64
) (
  input logic global_clk,
  input logic reset,
  spi_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  state_t st, nx;
  logic [CW-1:0] cnt;
  logic last, pend, sel, gnt, tmo;
  logic [DATA_W-1:0] tx_q, rx_q;
  assign gnt = (bus.req0 && bus.req1) ? !last : bus.req1;
  assign tmo = cnt == CW'(TIMEOUT - 1);
  always_comb begin
    nx = st;
    case (st)
      IDLE:    nx = (bus.req0 || bus.req1) ? START : IDLE;
      START:   nx = WAIT;
      WAIT:    nx = (bus.spi_done || tmo) ? DONE : WAIT;
      default: nx = IDLE;
    endcase
  end
  always_ff @(posedge global_clk) begin
    if (!reset) begin
      st <= IDLE;
      cnt <= '0;
      last <= 1'b1;
      pend <= 1'b0;
      sel <= 1'b0;
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      st <= nx;
      if (st == IDLE && nx == START) begin
        last <= gnt;
        sel <= gnt;
        tx_q <= gnt ? bus.tx1 : bus.tx0;
      end
      if (st == START) cnt <= '0;
      // a late spi_done on the final WAIT cycle still counts as success
      if (st == WAIT) begin
        if (bus.spi_done) begin
          rx_q <= bus.spi_rx;
          pend <= 1'b0;
        end else if (tmo) begin
          rx_q <= '0;
          pend <= 1'b1;
        end else cnt <= cnt + 1'b1;
      end
    end
  end
  assign bus.busy = reset && st != IDLE;
  assign bus.spi_start = reset && st == START;
  assign bus.ack0 = reset && st == DONE && !sel;
  assign bus.ack1 = reset && st == DONE && sel;
  assign bus.err = reset && st == DONE && pend;
  assign bus.spi_tx = tx_q;
  assign bus.spi_sel = sel;
  assign bus.rx_data = rx_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: scoreboard bench driving requesters and a scripted SPI master response
module tb_spi_arbiter;
  typedef struct {
    logic sel;
    logic [7:0] tx;
    logic [7:0] rx;
    logic err;
    int ws;
    int lat;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  int both_hi = 0;
  exp_t sb[$];
  bit st_ok, wd;
  int ws, who, lat, ns;
  logic s, e;
  logic [7:0] t, r;
  spi_arbiter_if #(.DATA_W(8)) bus ();
  spi_arbiter #(.DATA_W(8), .TIMEOUT(64)) dut (.global_clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) both_hi++;
  // d = WAIT cycle index on which spi_done is pulsed (negative: never)
  task automatic observe(input int d, input logic [7:0] rx, input bit drop, input bit early);
    st_ok = 0; ws = 0; who = -1; lat = 0; ns = 0; wd = 0; s = 0; t = 0; e = 0; r = 0;
    for (int i = 1; i <= 10 && !st_ok; i++) begin
      @(negedge clk);
      if (bus.spi_start === 1'b1) begin
        st_ok = 1; ws = i; s = bus.spi_sel; t = bus.spi_tx;
      end
    end
    if (!st_ok) return;
    if (early) begin bus.req0 = 0; bus.req1 = 0; end
    for (int k = 1; k <= 200 && who < 0; k++) begin
      @(negedge clk);
      if (bus.spi_start === 1'b1) ns++;
      if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
        who = bus.ack1 ? 1 : 0; e = bus.err; r = bus.rx_data; lat = k;
        if (drop) begin bus.req0 = 0; bus.req1 = 0; end
      end
      bus.spi_done = (k - 1 == d);
      bus.spi_rx = (k - 1 == d) ? rx : 8'($urandom);
    end
    if (who >= 0) begin
      @(negedge clk);
      wd = bus.ack0 | bus.ack1;
    end
    bus.spi_done = 0;
  endtask
  task automatic test_reset;
    reset = 0; bus.req0 = 1; bus.tx0 = 8'hC3;
    repeat (3) @(negedge clk);
    total++; if ({bus.ack0, bus.ack1, bus.err, bus.busy, bus.spi_start} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000", {bus.ack0, bus.ack1, bus.err, bus.busy, bus.spi_start});
    end
    total++; if ({bus.spi_tx, bus.spi_sel} !== 9'h0) begin
      bad++; $display("FAIL reset_spi got tx=%h sel=%b want tx=00 sel=0", bus.spi_tx, bus.spi_sel);
    end
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx got=%h want=00", bus.rx_data); end
    bus.req0 = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_idle busy got=%b want=0", bus.busy); end
  endtask
  task automatic test_single;
    exp_t x;
    sb.push_back('{1'b0, 8'hF0, 8'h0F, 1'b0, 1, 6});
    bus.tx0 = 8'hF0; bus.req0 = 1;
    observe(4, 8'h0F, 1, 0);
    x = sb.pop_front();
    total++; if ({s, t, r, e, 2'(who)} !== {x.sel, x.tx, x.rx, x.err, 2'(x.sel)}) begin
      bad++; $display("FAIL single_data got sel=%b tx=%h rx=%h err=%b ack=%0d want sel=%b tx=%h rx=%h err=%b", s, t, r, e, who, x.sel, x.tx, x.rx, x.err);
    end
    total++; if ({8'(ws), 8'(lat), 8'(ns), wd} !== {8'(x.ws), 8'(x.lat), 8'd0, 1'b0}) begin
      bad++; $display("FAIL single_timing got ws=%0d lat=%0d starts=%0d wide=%b want ws=%0d lat=%0d starts=0 wide=0", ws, lat, ns, wd, x.ws, x.lat);
    end
  endtask
  task automatic test_min_latency;
    exp_t x;
    sb.push_back('{1'b1, 8'h3C, 8'hC3, 1'b0, 1, 2});
    bus.tx1 = 8'h3C; bus.req1 = 1;
    observe(0, 8'hC3, 1, 0);
    x = sb.pop_front();
    total++; if ({s, t, r, e, 2'(who)} !== {x.sel, x.tx, x.rx, x.err, 2'(x.sel)}) begin
      bad++; $display("FAIL minlat_data got sel=%b tx=%h rx=%h err=%b ack=%0d want sel=%b tx=%h rx=%h err=%b", s, t, r, e, who, x.sel, x.tx, x.rx, x.err);
    end
    total++; if ({8'(ws), 8'(lat), 8'(ns), wd} !== {8'(x.ws), 8'(x.lat), 8'd0, 1'b0}) begin
      bad++; $display("FAIL minlat_timing got ws=%0d lat=%0d starts=%0d wide=%b want ws=%0d lat=%0d", ws, lat, ns, wd, x.ws, x.lat);
    end
  endtask
  task automatic test_round_robin;
    exp_t x;
    reset = 0;
    @(negedge clk);
    bus.tx0 = 8'hAA; bus.tx1 = 8'h55; bus.req0 = 1; bus.req1 = 1;
    for (int i = 0; i < 4; i++)
      sb.push_back('{1'(i % 2), (i % 2) ? 8'h55 : 8'hAA, 8'(8'h30 + i), 1'b0, 1, 3});
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      observe(1, 8'(8'h30 + i), i == 3, 0);
      x = sb.pop_front();
      total++; if ({s, t, r, e, 2'(who)} !== {x.sel, x.tx, x.rx, x.err, 2'(x.sel)}) begin
        bad++; $display("FAIL rr%0d_data got sel=%b tx=%h rx=%h err=%b ack=%0d want sel=%b tx=%h rx=%h err=%b", i, s, t, r, e, who, x.sel, x.tx, x.rx, x.err);
      end
      total++; if ({8'(ws), 8'(lat), 8'(ns), wd} !== {8'(x.ws), 8'(x.lat), 8'd0, 1'b0}) begin
        bad++; $display("FAIL rr%0d_timing got ws=%0d lat=%0d starts=%0d wide=%b want ws=%0d lat=%0d", i, ws, lat, ns, wd, x.ws, x.lat);
      end
    end
  endtask
  task automatic test_timeout;
    exp_t x;
    sb.push_back('{1'b1, 8'h77, 8'h00, 1'b1, 1, 65});
    bus.tx1 = 8'h77; bus.req1 = 1;
    observe(-1, 8'h00, 1, 0);
    x = sb.pop_front();
    total++; if ({s, t, r, e, 2'(who)} !== {x.sel, x.tx, x.rx, x.err, 2'(x.sel)}) begin
      bad++; $display("FAIL timeout_data got sel=%b tx=%h rx=%h err=%b ack=%0d want sel=%b tx=%h rx=%h err=%b", s, t, r, e, who, x.sel, x.tx, x.rx, x.err);
    end
    total++; if ({8'(ws), 8'(lat), 8'(ns), wd} !== {8'(x.ws), 8'(x.lat), 8'd0, 1'b0}) begin
      bad++; $display("FAIL timeout_timing got ws=%0d lat=%0d starts=%0d wide=%b want ws=%0d lat=%0d", ws, lat, ns, wd, x.ws, x.lat);
    end
  endtask
  task automatic test_done_on_timeout;
    exp_t x;
    sb.push_back('{1'b0, 8'h66, 8'h11, 1'b0, 1, 65});
    bus.tx0 = 8'h66; bus.req0 = 1;
    observe(63, 8'h11, 1, 0);
    x = sb.pop_front();
    total++; if ({s, t, r, e, 2'(who)} !== {x.sel, x.tx, x.rx, x.err, 2'(x.sel)}) begin
      bad++; $display("FAIL edge_data got sel=%b tx=%h rx=%h err=%b ack=%0d want sel=%b tx=%h rx=%h err=%b", s, t, r, e, who, x.sel, x.tx, x.rx, x.err);
    end
    total++; if ({8'(ws), 8'(lat), 8'(ns), wd} !== {8'(x.ws), 8'(x.lat), 8'd0, 1'b0}) begin
      bad++; $display("FAIL edge_timing got ws=%0d lat=%0d starts=%0d wide=%b want ws=%0d lat=%0d", ws, lat, ns, wd, x.ws, x.lat);
    end
  endtask
  task automatic test_rx_hold;
    int odd = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rx_data !== 8'h11 || bus.busy !== 1'b0 || bus.err !== 1'b0) odd++;
    end
    total++; if (odd != 0) begin bad++; $display("FAIL rx_hold got %0d bad cycles rx=%h want 0 rx=11", odd, bus.rx_data); end
  endtask
  task automatic test_drop_req;
    exp_t x;
    sb.push_back('{1'b1, 8'h12, 8'h21, 1'b0, 1, 4});
    bus.tx1 = 8'h12; bus.req1 = 1;
    observe(2, 8'h21, 1, 1);
    x = sb.pop_front();
    total++; if ({s, t, r, e, 2'(who)} !== {x.sel, x.tx, x.rx, x.err, 2'(x.sel)}) begin
      bad++; $display("FAIL drop_data got sel=%b tx=%h rx=%h err=%b ack=%0d want sel=%b tx=%h rx=%h err=%b", s, t, r, e, who, x.sel, x.tx, x.rx, x.err);
    end
    total++; if ({8'(ws), 8'(lat)} !== {8'(x.ws), 8'(x.lat)}) begin
      bad++; $display("FAIL drop_timing got ws=%0d lat=%0d want ws=%0d lat=%0d", ws, lat, x.ws, x.lat);
    end
  endtask
  task automatic test_reset_mid;
    bit seen = 0;
    int odd = 0;
    bus.tx0 = 8'h5A; bus.req0 = 1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.spi_start === 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL abort_start got no spi_start want one"); end
    repeat (3) @(negedge clk);
    reset = 0; bus.req0 = 0;
    @(negedge clk);
    total++; if ({bus.busy, bus.spi_start, bus.ack0, bus.ack1} !== 4'b0) begin
      bad++; $display("FAIL abort_reset got=%b want=0000", {bus.busy, bus.spi_start, bus.ack0, bus.ack1});
    end
    reset = 1;
    @(negedge clk);
    bus.spi_done = 1; bus.spi_rx = 8'h99;
    @(negedge clk);
    bus.spi_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.spi_start !== 1'b0 || bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) odd++;
    end
    total++; if (odd != 0) begin bad++; $display("FAIL abort_stray got %0d active cycles want 0", odd); end
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL abort_rx got=%h want=00", bus.rx_data); end
  endtask
  task automatic test_idle_done;
    int odd = 0;
    @(negedge clk);
    bus.spi_done = 1; bus.spi_rx = 8'hEE;
    @(negedge clk);
    bus.spi_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.rx_data !== 8'h00) odd++;
    end
    total++; if (odd != 0) begin bad++; $display("FAIL idle_done got %0d changed cycles rx=%h want 0", odd, bus.rx_data); end
  endtask
  task automatic test_final;
    total++; if (both_hi != 0) begin bad++; $display("FAIL dual_ack got=%0d want=0", both_hi); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
  endtask
  initial begin
    reset = 0;
    bus.req0 = 0; bus.req1 = 0; bus.tx0 = 0; bus.tx1 = 0; bus.spi_done = 0; bus.spi_rx = 0;
    test_reset();
    test_single();
    test_min_latency();
    test_round_robin();
    test_timeout();
    test_done_on_timeout();
    test_rx_hold();
    test_drop_req();
    test_reset_mid();
    test_idle_done();
    test_final();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
